// File: rtl/regfile_bist.sv
`default_nettype none
// ============================================================================
// Module   : regfile_bist
// Purpose  : Self-test initiator for register_file. Writes a seeded pattern to
//            all 32 registers, then reads them back two at a time and counts
//            mismatches. Define REGFILE_BIST_INV_PASS_EN for an inverted pass.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_bist #(
    parameter logic [31:0] SEED = 32'h5A5A_5A5A
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [5:0]  err_count,
    output logic [4:0]  first_err_addr,
    output logic        rf_we,
    output logic [4:0]  rf_rd_addr,
    output logic [31:0] rf_wdata,
    output logic [4:0]  rf_rs1_addr,
    output logic [4:0]  rf_rs2_addr,
    input  logic [31:0] rf_rs1_data,
    input  logic [31:0] rf_rs2_data
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WR   = 2'd1,
        S_RD   = 2'd2,
        S_FIN  = 2'd3
    } state_t;

    state_t      r_state, w_state_nxt;
    logic [4:0]  r_cnt, w_cnt_nxt;
    logic        r_err_seen, w_err_seen_nxt;
    logic        w_inv;
    logic        w_busy_nxt, w_done_nxt, w_pass_nxt;
    logic [5:0]  w_err_nxt;
    logic [4:0]  w_first_nxt;
    logic        w_we_nxt;
    logic [4:0]  w_rd_addr_nxt, w_rs1_nxt, w_rs2_nxt;
    logic [31:0] w_wdata_nxt;
    logic [31:0] w_exp1, w_exp2;
    logic        w_mis1, w_mis2;
    logic [1:0]  w_err_add;
    logic [6:0]  w_err_sum;
    logic [5:0]  w_err_sat;
    logic [3:0]  w_k_nxt;

`ifdef REGFILE_BIST_INV_PASS_EN
    logic r_inv, w_inv_nxt;
    assign w_inv = r_inv;
`else
    assign w_inv = 1'b0;
`endif

    function automatic logic [31:0] pattern(input logic [4:0] a, input logic inv);
        pattern = SEED ^ {a, a, a, a, a, a, a[1:0]} ^ {32{inv}};
    endfunction

    // x0 is hardwired to zero, so it is always expected to read back as 0
    assign w_exp1 = (rf_rs1_addr == 5'd0) ? 32'd0 : pattern(rf_rs1_addr, w_inv);
    assign w_exp2 = (rf_rs2_addr == 5'd0) ? 32'd0 : pattern(rf_rs2_addr, w_inv);
    assign w_mis1 = (r_state == S_RD) && (rf_rs1_data != w_exp1);
    assign w_mis2 = (r_state == S_RD) && (rf_rs2_data != w_exp2);

    assign w_err_add = {1'b0, w_mis1} + {1'b0, w_mis2};
    assign w_err_sum = {1'b0, err_count} + {5'd0, w_err_add};
    assign w_err_sat = (w_err_sum > 7'd63) ? 6'd63 : w_err_sum[5:0];
    assign w_k_nxt   = r_cnt[3:0] + 4'd1;

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
`ifdef REGFILE_BIST_INV_PASS_EN
        w_inv_nxt      = r_inv;
`endif
        w_busy_nxt     = busy;
        w_done_nxt     = done;
        w_pass_nxt     = pass;
        w_err_nxt      = err_count;
        w_first_nxt    = first_err_addr;
        w_err_seen_nxt = r_err_seen;
        w_we_nxt       = 1'b0;
        w_rd_addr_nxt  = 5'd0;
        w_wdata_nxt    = 32'd0;
        w_rs1_nxt      = 5'd0;
        w_rs2_nxt      = 5'd0;
        case (r_state)
            S_IDLE, S_FIN: begin
                if (start) begin
                    w_state_nxt    = S_WR;
                    w_cnt_nxt      = 5'd0;
`ifdef REGFILE_BIST_INV_PASS_EN
                    w_inv_nxt      = 1'b0;
`endif
                    w_busy_nxt     = 1'b1;
                    w_done_nxt     = 1'b0;
                    w_pass_nxt     = 1'b0;
                    w_err_nxt      = 6'd0;
                    w_first_nxt    = 5'd0;
                    w_err_seen_nxt = 1'b0;
                    w_we_nxt       = 1'b1;
                    w_wdata_nxt    = pattern(5'd0, 1'b0);
                end
            end
            S_WR: begin
                if (r_cnt == 5'd31) begin
                    w_state_nxt = S_RD;
                    w_cnt_nxt   = 5'd0;
                    w_rs2_nxt   = 5'd1;
                end else begin
                    w_cnt_nxt     = r_cnt + 5'd1;
                    w_we_nxt      = 1'b1;
                    w_rd_addr_nxt = r_cnt + 5'd1;
                    w_wdata_nxt   = pattern(r_cnt + 5'd1, w_inv);
                end
            end
            S_RD: begin
                w_err_nxt = w_err_sat;
                // rs1 wins when both ports miss on the first failing pair
                if ((w_mis1 || w_mis2) && !r_err_seen) begin
                    w_err_seen_nxt = 1'b1;
                    w_first_nxt    = w_mis1 ? rf_rs1_addr : rf_rs2_addr;
                end
                if (r_cnt[3:0] == 4'd15) begin
`ifdef REGFILE_BIST_INV_PASS_EN
                    if (!r_inv) begin
                        w_state_nxt = S_WR;
                        w_inv_nxt   = 1'b1;
                        w_cnt_nxt   = 5'd0;
                        w_we_nxt    = 1'b1;
                        w_wdata_nxt = pattern(5'd0, 1'b1);
                    end else
`endif
                    begin
                        w_state_nxt = S_FIN;
                        w_busy_nxt  = 1'b0;
                        w_done_nxt  = 1'b1;
                        w_pass_nxt  = (w_err_sat == 6'd0);
                    end
                end else begin
                    w_cnt_nxt = {1'b0, w_k_nxt};
                    w_rs1_nxt = {w_k_nxt, 1'b0};
                    w_rs2_nxt = {w_k_nxt, 1'b1};
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= S_IDLE;
            r_cnt          <= 5'd0;
`ifdef REGFILE_BIST_INV_PASS_EN
            r_inv          <= 1'b0;
`endif
            r_err_seen     <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            err_count      <= 6'd0;
            first_err_addr <= 5'd0;
            rf_we          <= 1'b0;
            rf_rd_addr     <= 5'd0;
            rf_wdata       <= 32'd0;
            rf_rs1_addr    <= 5'd0;
            rf_rs2_addr    <= 5'd0;
        end else begin
            r_state        <= w_state_nxt;
            r_cnt          <= w_cnt_nxt;
`ifdef REGFILE_BIST_INV_PASS_EN
            r_inv          <= w_inv_nxt;
`endif
            r_err_seen     <= w_err_seen_nxt;
            busy           <= w_busy_nxt;
            done           <= w_done_nxt;
            pass           <= w_pass_nxt;
            err_count      <= w_err_nxt;
            first_err_addr <= w_first_nxt;
            rf_we          <= w_we_nxt;
            rf_rd_addr     <= w_rd_addr_nxt;
            rf_wdata       <= w_wdata_nxt;
            rf_rs1_addr    <= w_rs1_nxt;
            rf_rs2_addr    <= w_rs2_nxt;
        end
    end

endmodule
`default_nettype wire

// File: doc/regfile_bist.md
# regfile_bist

Built-in self-test initiator for `register_file`. On a `start` pulse it takes over the register file's write and read ports, writes a deterministic pattern to all 32 addresses, and reads them back two at a time through rs1/rs2. It compares each read against the expected value, with x0 always expected as zero. It sits beside the core's register file behind a port mux selected by `busy`, and reports pass/fail, an error count and the first failing address.

## Interface
Parameters (XLEN and REG_ADDR_WIDTH come from `riscv_pkg`, 32 and 5):
- SEED, 32'h5A5A_5A5A, base pattern XORed into every written word.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle request to run the test; honoured only in IDLE or FIN.
- busy  output  1  high while the BIST owns the register file ports.
- done  output  1  sticky completion flag; cleared by the next accepted start or by reset.
- pass  output  1  valid when done=1: 1 = zero mismatches.
- err_count  output  6  number of mismatching reads, saturates at 63.
- first_err_addr  output  5  address of the first mismatch; 0 if none.
- rf_we  output  1  to register_file reg_write_enable.
- rf_rd_addr  output  5  write address.
- rf_wdata  output  XLEN  write data.
- rf_rs1_addr  output  5  read port 1 address.
- rf_rs2_addr  output  5  read port 2 address.
- rf_rs1_data  input  XLEN  read port 1 data, combinational from rf_rs1_addr.
- rf_rs2_data  input  XLEN  read port 2 data, combinational from rf_rs2_addr.

## Operation
- Pattern: P(i) = SEED ^ {i,i,i,i,i,i,i[1:0]} for i = 0..31, 32 bits. Pass 0 writes P(i). Pass 1 writes ~P(i).
- Expected read value E(i) = 0 for i = 0, otherwise the value written in the current pass.
- FSM states: IDLE, WR, RD, FIN.
- IDLE/FIN + start → WR. Pass = 0, address counter = 0, err_count = 0, first_err_addr = 0, done = 0.
- WR: rf_we = 1, rf_rd_addr = counter, rf_wdata = pattern(counter). The counter increments every cycle. At counter 31 the FSM goes to RD and the counter resets to 0.
- RD: rf_rs1_addr = 2k and rf_rs2_addr = 2k+1 for k = 0..15, one pair per cycle. Both ports are compared at the clock edge. Each mismatch adds 1 to err_count (saturating), so 0, 1 or 2 per cycle.
- first_err_addr latches on the first mismatch only. If both ports mismatch in that same cycle, it latches the rs1 address.
- After k = 15: if pass = 0 and the second pass is enabled, go to WR with pass = 1. Otherwise go to FIN.
- FIN: done = 1, pass = (err_count == 0), busy = 0. Hold until start.
- start in WR or RD is ignored.
- rf_we is 0 in every state except WR. Read addresses are 0 outside RD.

## Timing
- All outputs are registered. Reset values: busy = 0, done = 0, pass = 0, err_count = 0, first_err_addr = 0, rf_we = 0, all addresses and rf_wdata = 0. The FSM resets to IDLE.
- Reset is asynchronous. Asserting it mid-run drops rf_we and busy immediately, with no partial state retained.
- start sampled at edge N gives busy = 1 and rf_we = 1 after N. Writes land at edges N+1..N+32.
- Reads are compared at edges N+33..N+48.
- With two passes, done rises after edge N+96. With one pass, it rises after edge N+48.
- Read data is sampled in the same cycle its address is driven. The register file read path must be combinational.

## Configuration
- `REGFILE_BIST_INV_PASS_EN` defined: both passes run (P, then ~P), so every bit is tested at both 0 and 1. Total 96 cycles, up to 64 compares.
- `REGFILE_BIST_INV_PASS_EN` undefined: pass 0 only. Total 48 cycles, up to 32 compares. The pass-1 logic is compiled out.

## Test plan
- Reset → all outputs 0 and FSM idle. start with rst_n = 0 → no response.
- Fault-free register_file, SEED = 0, start → busy for 96 cycles. done = 1, pass = 1, err_count = 0, first_err_addr = 0.
- Model x5 bit 0 stuck-at-0, SEED = 0 → pass 0 writes bit 0 = 1 and mismatches; pass 1 expects 0 and matches. Required: err_count = 1, first_err_addr = 5, pass = 0.
- Model x0 as writable, SEED = 0 → pass 0 writes 0 and matches; pass 1 reads 32'hFFFF_FFFF and mismatches. Required: err_count = 1, first_err_addr = 0.
- Pulse start at cycle 10 of the run → ignored, done still after 96 cycles. Assert rst_n = 0 at cycle 40 of a new run → busy = 0 and rf_we = 0 immediately. A subsequent start completes normally.
- Macro undefined, fault-free register file → done after 48 cycles, pass = 1. All-bits-stuck-at-1 model → err_count = 32, first_err_addr = 0.
